alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Round-robin controller that shares one 8-bit combinational alu (A, B, sel -> Y) among
//   NUM_REQ requesters. Each requester uses a valid/ready handshake to issue an
//   {A, B, sel} operation and receives the result on a per-requester response handshake.
//   The block sits between client FSMs and the alu, drives the alu inputs from registers,
//   and captures alu Y after EXEC_CYCLES cycles.
// PARAMETERS
//   NUM_REQ      4   number of requesters, legal range 2..8
//   EXEC_CYCLES  1   cycles alu inputs are held stable before Y is captured, range 1..15
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   req_valid  in   NUM_REQ    per-requester request valid
//   req_ready  out  NUM_REQ    per-requester accept (one-hot or zero)
//   req_a      in   8*NUM_REQ  operand A; requester i uses bits [8i+7:8i]
//   req_b      in   8*NUM_REQ  operand B; requester i uses bits [8i+7:8i]
//   req_sel    in   3*NUM_REQ  alu opcode; requester i uses bits [3i+2:3i]
//   rsp_valid  out  NUM_REQ    per-requester result valid (one-hot or zero)
//   rsp_ready  in   NUM_REQ    per-requester result accept
//   rsp_y      out  8          result, shared by all requesters; qualified by rsp_valid
//   rsp_err    out  1          set when the op was divide (sel=3'b011) with B==0
//   busy       out  1          high in every state except IDLE
//   alu_a      out  8          registered operand to alu A
//   alu_b      out  8          registered operand to alu B
//   alu_sel    out  3          registered opcode to alu sel
//   alu_y      in   8          alu Y
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     - state=IDLE; all outputs 0.
//     - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
//   FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE:
//     - Grant g = first i in order last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ)
//       with req_valid[i]=1.
//     - req_ready[g] is combinational, asserted only in IDLE. The handshake completes
//       in that same cycle.
//     - On the handshake edge: latch req_a/b/sel of g into alu_a/b/sel; store g;
//       load the counter with EXEC_CYCLES-1; go to EXEC.
//     - No valid request: stay in IDLE.
//   EXEC:
//     - alu_a/b/sel are held constant.
//     - When counter==0: rsp_y<=alu_y, rsp_err<=(alu_sel==3'b011 && alu_b==0), go to RESP.
//     - Otherwise decrement the counter.
//   RESP:
//     - rsp_valid[g]=1; rsp_y and rsp_err stay stable until the handshake.
//     - On rsp_ready[g]: last_grant<=g, go to IDLE.
//     - rsp_ready bits of other requesters are ignored.
//   Latency, request handshake at cycle T:
//     - rsp_valid rises at T+EXEC_CYCLES+1.
//     - With zero backpressure the next accept is at T+EXEC_CYCLES+2.
//   Requesters hold valid and operands stable until ready. A requester dropping valid
//   before grant loses only that arbitration round.
//   rsp_y is the alu 8-bit result unchanged: mod-256 wrap for add, sub, mul and shifts;
//   8'hFF for divide by zero.
//   Reset mid-EXEC or mid-RESP aborts the transaction. No response is ever delivered for it.
//   At most one request is in flight; req_ready is all-zero outside IDLE.
// TESTING
//   1. req0: A=5, B=3, sel=000, accepted at T -> rsp_valid[0] at T+2, rsp_y=8'h08,
//      rsp_err=0.
//   2. req2: A=10, B=0, sel=011 -> rsp_y=8'hFF, rsp_err=1.
//      Then A=200, B=100, sel=000 -> rsp_y=8'h2C (wrap).
//   3. All 4 req_valid held high, rsp_ready tied high -> grant order 0,1,2,3,0,1,
//      one accept every 3 cycles.
//   4. rsp_ready[1] held low 5 cycles in RESP -> rsp_valid[1], rsp_y, rsp_err stable;
//      req_ready stays 0 despite req_valid[0]=1.
//   5. EXEC_CYCLES=4: alu_a/b/sel stable for 4 cycles; rsp_valid rises at T+5.
//   6. rst_n pulsed low during EXEC -> all outputs 0 immediately, no rsp_valid.
//      After release with req 0 and 3 valid, requester 0 is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational 8-bit alu among NUM_REQ valid/ready requesters.
// Operands are registered toward the alu; the result is captured after EXEC_CYCLES cycles.
module alu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    input  logic [3*NUM_REQ-1:0]   req_sel,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [7:0]             rsp_y,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [2:0]             alu_sel,
    input  logic [7:0]             alu_y
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [GW-1:0]   last_grant_r;
    logic [GW-1:0]   grant_r;
    logic [GW-1:0]   grant_s;
    logic [GW-1:0]   cand_s;
    logic            found_s;
    int              scan_idx_s;
    logic [3:0]      cnt_r;
    logic [7:0]      op_a_s;
    logic [7:0]      op_b_s;
    logic [2:0]      op_sel_s;

    function automatic logic is_div_zero(input logic [2:0] sel, input logic [7:0] b);
        return (sel == 3'b011) && (b == 8'h00);
    endfunction

    // Round-robin scan starting just after the last served requester.
    always_comb begin
        found_s    = 1'b0;
        grant_s    = {GW{1'b0}};
        cand_s     = {GW{1'b0}};
        scan_idx_s = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx_s = (int'(last_grant_r) + k) % NUM_REQ;
            cand_s     = scan_idx_s[GW-1:0];
            if (!found_s && req_valid[cand_s]) begin
                found_s = 1'b1;
                grant_s = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Operand mux for the requester being granted.
    always_comb begin
        op_a_s   = 8'h00;
        op_b_s   = 8'h00;
        op_sel_s = 3'b000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s == GW'(i)) begin
                op_a_s   = req_a[8*i +: 8];
                op_b_s   = req_b[8*i +: 8];
                op_sel_s = req_sel[3*i +: 3];
            end else begin
                op_a_s = op_a_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (found_s) state_nxt_s = EXEC; else state_nxt_s = IDLE;
            EXEC:    if (cnt_r == 4'd0) state_nxt_s = RESP; else state_nxt_s = EXEC;
            RESP:    if (rsp_ready[grant_r]) state_nxt_s = IDLE; else state_nxt_s = RESP;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs; req_ready is masked while reset is asserted so every output reads 0.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        rsp_valid = {NUM_REQ{1'b0}};
        busy      = 1'b0;
        case (state_r)
            IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (rst_n && found_s && (grant_s == GW'(i))) req_ready[i] = 1'b1;
                    else req_ready[i] = 1'b0;
                end
            end
            EXEC: busy = 1'b1;
            RESP: begin
                busy = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_r == GW'(i)) rsp_valid[i] = 1'b1;
                    else rsp_valid[i] = 1'b0;
                end
            end
            default: busy = 1'b0;
        endcase
    end

    // Datapath: operand latch, exec counter, result capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_sel      <= 3'b000;
            rsp_y        <= 8'h00;
            rsp_err      <= 1'b0;
            cnt_r        <= 4'd0;
            grant_r      <= {GW{1'b0}};
            last_grant_r <= GW'(NUM_REQ - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        alu_a   <= op_a_s;
                        alu_b   <= op_b_s;
                        alu_sel <= op_sel_s;
                        grant_r <= grant_s;
                        cnt_r   <= 4'(EXEC_CYCLES - 1);
                    end
                end
                EXEC: begin
                    if (cnt_r == 4'd0) begin
                        rsp_y   <= alu_y;
                        rsp_err <= is_div_zero(alu_sel, alu_b);
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_r]) last_grant_r <= grant_r;
                end
                default: cnt_r <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with EXEC_CYCLES=1 and one with EXEC_CYCLES=4,
// each driving a small behavioural alu.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'h0, req_ready, rsp_valid, rsp_ready = 4'h0;
    logic [31:0] req_a = 32'h0, req_b = 32'h0;
    logic [11:0] req_sel = 12'h0;
    logic [7:0]  rsp_y, alu_a, alu_b, alu_y;
    logic [2:0]  alu_sel;
    logic        rsp_err, busy;

    logic [3:0]  req_valid4 = 4'h0, req_ready4, rsp_valid4, rsp_ready4 = 4'h0;
    logic [31:0] req_a4 = 32'h0, req_b4 = 32'h0;
    logic [11:0] req_sel4 = 12'h0;
    logic [7:0]  rsp_y4, alu_a4, alu_b4, alu_y4;
    logic [2:0]  alu_sel4;
    logic        rsp_err4, busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        case (sel)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return (b == 8'h00) ? 8'hFF : a / b;
            3'd4:    return a << b[2:0];
            3'd5:    return a >> b[2:0];
            3'd6:    return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_y  = alu_f(alu_a, alu_b, alu_sel);
    assign alu_y4 = alu_f(alu_a4, alu_b4, alu_sel4);

    alu_arbiter #(.NUM_REQ(4), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y)
    );

    alu_arbiter #(.NUM_REQ(4), .EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_a(req_a4), .req_b(req_b4), .req_sel(req_sel4), .rsp_valid(rsp_valid4),
        .rsp_ready(rsp_ready4), .rsp_y(rsp_y4), .rsp_err(rsp_err4), .busy(busy4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_y(alu_y4)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request on requester i and return on the negedge after its accept edge.
    task automatic send(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        bit got = 1'b0;
        req_valid[i]     = 1'b1;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_sel[3*i +: 3] = sel;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (req_ready[i]) got = 1'b1;
            else @(negedge clk);
        end
        check_val("accept_timeout", 32'(got), 32'd1);
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    // Wait for requester i's response, check it and complete the handshake.
    task automatic wait_rsp(input int i, input logic [7:0] ey, input logic ee, input string tag);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (rsp_valid[i]) got = 1'b1;
            else @(negedge clk);
        end
        check_val({tag, "_rsp_timeout"}, 32'(got), 32'd1);
        check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1 << i);
        check_val({tag, "_rsp_y"}, 32'(rsp_y), 32'(ey));
        check_val({tag, "_rsp_err"}, 32'(rsp_err), 32'(ee));
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        #1;
        check_val({tag, "_back_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[6];
        int acc_cnt;
        int last_cyc;
        exp_order = '{0, 1, 2, 3, 0, 1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_alu_a", 32'(alu_a), 32'd0);
        check_val("rst_rsp_y", 32'(rsp_y), 32'd0);
        rst_n = 1'b1;

        // 1: add, latency T+2
        send(0, 8'd5, 8'd3, 3'b000);
        check_val("t1_exec_busy", 32'(busy), 32'd1);
        check_val("t1_exec_no_rsp", 32'(rsp_valid), 32'd0);
        check_val("t1_alu_a", 32'(alu_a), 32'd5);
        check_val("t1_alu_b", 32'(alu_b), 32'd3);
        check_val("t1_exec_no_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        check_val("t1_rsp_at_t2", 32'(rsp_valid), 32'h1);
        wait_rsp(0, 8'h08, 1'b0, "t1");

        // 2: divide by zero, then add with wrap
        send(2, 8'd10, 8'd0, 3'b011);
        wait_rsp(2, 8'hFF, 1'b1, "t2_div0");
        send(2, 8'd200, 8'd100, 3'b000);
        wait_rsp(2, 8'h2C, 1'b0, "t2_wrap");

        // 3: all requesters valid, no backpressure
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[8*i +: 8]   = 8'(10 * (i + 1));
            req_b[8*i +: 8]   = 8'(i);
            req_sel[3*i +: 3] = 3'b000;
        end
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        acc_cnt   = 0;
        last_cyc  = -1;
        for (int c = 0; c < 40 && acc_cnt < 6; c++) begin
            #1;
            for (int j = 0; j < 4; j++)
                if (rsp_valid[j]) check_val("t3_rr_y", 32'(rsp_y), 32'(8'(10 * (j + 1) + j)));
            if (req_ready != 4'h0) begin
                check_val("t3_grant", 32'(req_ready), 32'd1 << exp_order[acc_cnt]);
                if (acc_cnt > 0) check_val("t3_spacing", 32'(c - last_cyc), 32'd3);
                last_cyc = c;
                acc_cnt++;
            end
            @(negedge clk);
        end
        check_val("t3_accept_count", 32'(acc_cnt), 32'd6);
        req_valid = 4'h0;
        repeat (3) @(negedge clk);
        rsp_ready = 4'h0;

        // 4: backpressure on requester 1 while requester 0 waits
        send(1, 8'd7, 8'd6, 3'b010);
        req_valid[0]    = 1'b1;
        req_a[7:0]      = 8'd1;
        req_b[7:0]      = 8'd1;
        req_sel[2:0]    = 3'b000;
        rsp_ready       = 4'b0001;
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            #1;
            check_val("t4_rsp_valid_hold", 32'(rsp_valid), 32'h2);
            check_val("t4_rsp_y_hold", 32'(rsp_y), 32'h2A);
            check_val("t4_rsp_err_hold", 32'(rsp_err), 32'd0);
            check_val("t4_no_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        rsp_ready = 4'b0000;
        #1;
        check_val("t4_req0_next", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(0, 8'h02, 1'b0, "t4_req0");

        // 5: EXEC_CYCLES=4 instance
        req_valid4[0] = 1'b1;
        req_a4[7:0]   = 8'd9;
        req_b4[7:0]   = 8'd12;
        req_sel4[2:0] = 3'b001;
        #1;
        check_val("t5_accept", 32'(req_ready4), 32'h1);
        @(negedge clk);
        req_valid4[0] = 1'b0;
        req_a4[7:0]   = 8'h55;
        for (int n = 1; n <= 4; n++) begin
            #1;
            check_val("t5_alu_a_hold", 32'(alu_a4), 32'd9);
            check_val("t5_alu_b_hold", 32'(alu_b4), 32'd12);
            check_val("t5_alu_sel_hold", 32'(alu_sel4), 32'd1);
            check_val("t5_no_rsp_yet", 32'(rsp_valid4), 32'd0);
            @(negedge clk);
        end
        #1;
        check_val("t5_rsp_at_t5", 32'(rsp_valid4), 32'h1);
        check_val("t5_rsp_y", 32'(rsp_y4), 32'hFD);
        check_val("t5_rsp_err", 32'(rsp_err4), 32'd0);
        rsp_ready4[0] = 1'b1;
        @(negedge clk);
        rsp_ready4[0] = 1'b0;

        // 6: reset during EXEC aborts the transaction
        send(2, 8'd4, 8'd4, 3'b010);
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        req_a[7:0]   = 8'd3;
        req_b[7:0]   = 8'd3;
        req_sel[2:0] = 3'b000;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        check_val("t6_rst_alu_a", 32'(alu_a), 32'd0);
        check_val("t6_rst_alu_sel", 32'(alu_sel), 32'd0);
        check_val("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("t6_rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("t6_req0_first", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(0, 8'h06, 1'b0, "t6_req0");
        req_valid = 4'h0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
